// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank: S=R=1 rule encodings and the
// per-bit next-state function used by every channel.
package sr_pkg;

    localparam int unsigned SR_MODE_RDOM = 0;  // S=R=1 -> 0
    localparam int unsigned SR_MODE_SDOM = 1;  // S=R=1 -> 1
    localparam int unsigned SR_MODE_HOLD = 2;  // S=R=1 -> keep q
    localparam int unsigned SR_MODE_TOG  = 3;  // S=R=1 -> ~q

    // Next state of one enabled SR channel; every input combination is defined.
    function automatic logic sr_next(
        input logic       q,
        input logic       s,
        input logic       r,
        input logic [1:0] mode
    );
        logic nq;
        nq = q;
        case ({s, r})
            2'b00: nq = q;
            2'b01: nq = 1'b0;
            2'b10: nq = 1'b1;
            2'b11: begin
                case (mode)
                    2'(SR_MODE_RDOM): nq = 1'b0;
                    2'(SR_MODE_SDOM): nq = 1'b1;
                    2'(SR_MODE_HOLD): nq = q;
                    default:          nq = ~q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// One SR channel: next-state selection plus registered q, qbar and edge pulses.
module sr_bit_cell
    import sr_pkg::*;
#(
    parameter int unsigned MODE    = SR_MODE_RDOM,
    parameter logic        RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar,
    output logic rise,
    output logic fall
);

    localparam logic [1:0] MODE_SEL = 2'(MODE);

    logic q_next;

    // Next state: clear beats enable, enable beats hold.
    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = RST_BIT;
        end else if (en) begin
            q_next = sr_next(q, s, r, MODE_SEL);
        end
    end

    // State, complement and edge pulses all registered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_BIT;
            qbar <= ~RST_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            q    <= q_next;
            qbar <= ~q_next;
            rise <= q_next & ~q;
            fall <= ~q_next & q;
        end
    end

endmodule

// File: rtl/sr_ff_bank.sv
// WIDTH-channel bank of clocked SR flip-flops with a selectable S=R=1 rule,
// conflict flag and saturating conflict-cycle counter.
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       MODE    = SR_MODE_RDOM,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (MODE > 3) begin : g_bad_mode
        $error("sr_ff_bank: MODE must be in 0..3");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sr_ff_bank: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sr_ff_bank: CNT_W must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_bit_cell #(
            .MODE    (MODE),
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .clr   (clr),
            .s     (s[i]),
            .r     (r[i]),
            .q     (q[i]),
            .qbar  (qbar[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    logic conflict_hit;

    // A conflict cycle is any enabled, non-cleared edge with at least one S=R=1 bit.
    always_comb begin
        conflict_hit = en & ~clr & (|(s & r));
    end

    // Conflict flag and per-cycle saturating counter; clear zeroes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            conflict <= conflict_hit;
            if (clr) begin
                conflict_cnt <= '0;
            end else if (conflict_hit && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench: four banks (one per MODE) share stimulus; a behavioural
// model derived from the S/R rules is compared against all of them every edge.
module tb_sr_ff_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] s;
    logic [7:0] r;

    logic [7:0] q_o    [4];
    logic [7:0] qbar_o [4];
    logic [7:0] rise_o [4];
    logic [7:0] fall_o [4];
    logic       conf_o [4];
    logic [1:0] cnt0;
    logic [7:0] cnt1, cnt2, cnt3;

    sr_ff_bank #(.WIDTH(8), .MODE(0), .RST_VAL(8'h00), .CNT_W(2)) u_m0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
        .q(q_o[0]), .qbar(qbar_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
        .conflict(conf_o[0]), .conflict_cnt(cnt0));
    sr_ff_bank #(.WIDTH(8), .MODE(1), .RST_VAL(8'h00), .CNT_W(8)) u_m1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
        .q(q_o[1]), .qbar(qbar_o[1]), .rise(rise_o[1]), .fall(fall_o[1]),
        .conflict(conf_o[1]), .conflict_cnt(cnt1));
    sr_ff_bank #(.WIDTH(8), .MODE(2), .RST_VAL(8'h5A), .CNT_W(8)) u_m2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
        .q(q_o[2]), .qbar(qbar_o[2]), .rise(rise_o[2]), .fall(fall_o[2]),
        .conflict(conf_o[2]), .conflict_cnt(cnt2));
    sr_ff_bank #(.WIDTH(8), .MODE(3), .RST_VAL(8'h00), .CNT_W(8)) u_m3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
        .q(q_o[3]), .qbar(qbar_o[3]), .rise(rise_o[3]), .fall(fall_o[3]),
        .conflict(conf_o[3]), .conflict_cnt(cnt3));

    int checks = 0;
    int errors = 0;

    // Reference state per instance (instance index == MODE)
    logic [7:0] rst_v  [4];
    int         cnt_mx [4];
    logic [7:0] m_q    [4];
    logic [7:0] m_rise [4];
    logic [7:0] m_fall [4];
    logic       m_conf [4];
    int         m_cnt  [4];

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] s;
        logic [7:0] r;
        logic [3:0] exp_q0;  // bit m = expected q[0] of the MODE=m bank
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] act_cnt(input int m);
        case (m)
            0:       return {30'b0, cnt0};
            1:       return {24'b0, cnt1};
            2:       return {24'b0, cnt2};
            default: return {24'b0, cnt3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            m_q[m]    = rst_v[m];
            m_rise[m] = 8'h00;
            m_fall[m] = 8'h00;
            m_conf[m] = 1'b0;
            m_cnt[m]  = 0;
        end
    endtask

    // Applies the S/R rules to the current inputs for one clock edge.
    task automatic model_step();
        for (int m = 0; m < 4; m++) begin
            logic [7:0] nq;
            logic       hit;
            nq = m_q[m];
            if (clr) begin
                nq = rst_v[m];
            end else if (en) begin
                for (int i = 0; i < 8; i++) begin
                    if (s[i] && !r[i])      nq[i] = 1'b1;
                    else if (!s[i] && r[i]) nq[i] = 1'b0;
                    else if (s[i] && r[i]) begin
                        if (m == 0)      nq[i] = 1'b0;
                        else if (m == 1) nq[i] = 1'b1;
                        else if (m == 3) nq[i] = !m_q[m][i];
                    end
                end
            end
            hit       = en && !clr && ((s & r) != 8'h00);
            m_rise[m] = nq & ~m_q[m];
            m_fall[m] = ~nq & m_q[m];
            m_q[m]    = nq;
            m_conf[m] = hit;
            if (clr)                           m_cnt[m] = 0;
            else if (hit && m_cnt[m] < cnt_mx[m]) m_cnt[m] = m_cnt[m] + 1;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("q[m%0d]", m),        {24'b0, q_o[m]},    {24'b0, m_q[m]});
            chk($sformatf("qbar[m%0d]", m),     {24'b0, qbar_o[m]}, {24'b0, ~m_q[m]});
            chk($sformatf("rise[m%0d]", m),     {24'b0, rise_o[m]}, {24'b0, m_rise[m]});
            chk($sformatf("fall[m%0d]", m),     {24'b0, fall_o[m]}, {24'b0, m_fall[m]});
            chk($sformatf("conflict[m%0d]", m), {31'b0, conf_o[m]}, {31'b0, m_conf[m]});
            chk($sformatf("cnt[m%0d]", m),      act_cnt(m),         m_cnt[m]);
            chk($sformatf("qbar_inv[m%0d]", m), {24'b0, qbar_o[m] ^ q_o[m]}, 32'hFF);
            chk($sformatf("rise_and_fall[m%0d]", m), {24'b0, rise_o[m] & fall_o[m]}, 32'h0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic e, input logic c, input logic [7:0] sv, input logic [7:0] rv);
        en  = e;
        clr = c;
        s   = sv;
        r   = rv;
    endtask

    initial begin
        rst_v[0] = 8'h00; rst_v[1] = 8'h00; rst_v[2] = 8'h5A; rst_v[3] = 8'h00;
        cnt_mx[0] = 3; cnt_mx[1] = 255; cnt_mx[2] = 255; cnt_mx[3] = 255;

        vecs[0] = '{1'b1, 1'b0, 8'h01, 8'h00, 4'b1111};
        vecs[1] = '{1'b1, 1'b0, 8'h01, 8'h01, 4'b0110};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 4'b0110};
        vecs[3] = '{1'b1, 1'b0, 8'h01, 8'h00, 4'b1111};
        vecs[4] = '{1'b1, 1'b0, 8'h01, 8'h01, 4'b0110};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h01, 4'b0000};
        vecs[6] = '{1'b1, 1'b0, 8'h01, 8'h01, 4'b1010};
        vecs[7] = '{1'b0, 1'b0, 8'h01, 8'h00, 4'b1010};
        vecs[8] = '{1'b1, 1'b1, 8'h01, 8'h00, 4'b0000};

        // Power-on reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        #12;
        check_all();
        #10 rst_n = 1'b1;

        // Truth table across all four modes
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].en, vecs[v].clr, vecs[v].s, vecs[v].r);
            tick();
            for (int m = 0; m < 4; m++) begin
                chk($sformatf("vec%0d_q0[m%0d]", v, m), {31'b0, q_o[m][0]}, {31'b0, vecs[v].exp_q0[m]});
            end
        end

        // Toggle mode: q[0] alternates, rise/fall alternate
        drive(1'b1, 1'b0, 8'h01, 8'h01);
        for (int k = 0; k < 4; k++) begin
            logic exp_q;
            exp_q = (k % 2 == 0);
            tick();
            chk($sformatf("tog%0d_q0", k),    {31'b0, q_o[3][0]},    {31'b0, exp_q});
            chk($sformatf("tog%0d_rise0", k), {31'b0, rise_o[3][0]}, {31'b0, exp_q});
            chk($sformatf("tog%0d_fall0", k), {31'b0, fall_o[3][0]}, {31'b0, !exp_q});
        end

        // Saturation of the 2-bit counter; multi-bit conflicts count once
        drive(1'b0, 1'b1, 8'h00, 8'h00);
        tick();
        chk("sat_clr0", act_cnt(0), 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1'b1, 1'b0, 8'h01, 8'h01);
            else        drive(1'b1, 1'b0, 8'hFF, 8'hFF);
            tick();
            chk($sformatf("sat%0d_cnt0", k), act_cnt(0), (k < 3) ? k + 1 : 3);
            chk($sformatf("sat%0d_cnt1", k), act_cnt(1), k + 1);
        end
        drive(1'b1, 1'b1, 8'hFF, 8'hFF);
        tick();
        chk("sat_clr1", act_cnt(0), 0);

        // Enable and clear
        drive(1'b1, 1'b0, 8'hA5, 8'h5A);
        tick();
        chk("load_a5", {24'b0, q_o[0]}, 32'hA5);
        drive(1'b0, 1'b0, 8'hFF, 8'h00);
        tick();
        chk("en0_hold", {24'b0, q_o[0]}, 32'hA5);
        drive(1'b1, 1'b1, 8'hFF, 8'h00);
        tick();
        chk("clr_q_m0",    {24'b0, q_o[0]},    32'h00);
        chk("clr_fall_m0", {24'b0, fall_o[0]}, 32'hA5);
        chk("clr_q_m2",    {24'b0, q_o[2]},    32'h5A);
        chk("clr_rise_m2", {24'b0, rise_o[2]}, 32'h5A);

        // Asynchronous reset mid-cycle with live state and a nonzero counter
        drive(1'b1, 1'b0, 8'hFF, 8'hFF);
        tick();
        drive(1'b1, 1'b0, 8'hA5, 8'h5A);
        tick();
        chk("pre_rst_q", {24'b0, q_o[1]}, 32'hA5);
        chk("pre_rst_cnt", act_cnt(1), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_q_m2", {24'b0, q_o[2]}, 32'h5A);
        #2 rst_n = 1'b1;

        // Random traffic against the reference model
        for (int n = 0; n < 10000; n++) begin
            drive(($urandom_range(3) != 0), ($urandom_range(15) == 0),
                  8'($urandom), 8'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
